// File: rtl/dphy_pkg.sv
// dphy_pkg: shared types and helpers for the D-PHY lane deskew block.
//   deskew_state_t : deskew FSM state encoding
//   BYTE_W         : width of one lane byte
//   ptr_w()        : FIFO pointer width (index bits plus one wrap bit)
package dphy_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    RESYNC = 2'd3
  } deskew_state_t;

  // The extra bit tells a full FIFO apart from an empty one when the indices match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dphy_deskew_fifo.sv
// dphy_deskew_fifo: per-lane deskew FIFO built from a register array.
//   clk_i, rst_n_i : byte clock, async active-low reset
//   wr_en_i/wr_data_i : push one byte
//   rd_en_i        : pop one byte (ignored when empty)
//   flush_i        : synchronous clear of both pointers, has priority over push/pop
//   rd_data_o      : head of FIFO (valid when !empty_o)
//   empty_o/full_o : occupancy flags
//   overflow_o     : push attempted while full with no pop in the same cycle
// DEPTH need not be a power of two; the index wraps at DEPTH-1.
module dphy_deskew_fifo
  import dphy_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              flush_i,
  output logic [BYTE_W-1:0] rd_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int IW = PW - 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              do_wr, do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p[IW-1:0] == IW'(DEPTH - 1)) begin
      return {~p[PW-1], {IW{1'b0}}};
    end
    return p + PW'(1);
  endfunction

  always_comb begin
    empty_o    = (wr_ptr_q == rd_ptr_q);
    full_o     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    do_rd      = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so full+pop+push is legal.
    do_wr      = wr_en_i && (!full_o || do_rd);
    overflow_o = wr_en_i && full_o && !do_rd;
    rd_data_o  = mem_q[rd_ptr_q[IW-1:0]];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr && !flush_i) mem_q[wr_ptr_q[IW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/dphy_lane_deskew.sv
// dphy_lane_deskew: multi-lane word aligner with per-lane deskew FIFOs.
//   clk_i, rst_n_i : byte clock, async active-low reset
//   enable_i       : 0 flushes FIFOs and keeps the block idle
//   pkt_done_i     : end-of-packet pulse, triggers a resync
//   byte_i/byte_valid_i : per-lane bytes from the byte aligners
//   sync_reset_o   : one-cycle resync request to the byte aligners
//   word_o/valid_o : lane-aligned word, lane i in bits [8i+7:8i]
//   skew_err_o     : one-cycle pulse on skew window exceeded or FIFO overflow
// Optional build macro DPHY_DESKEW_STATS_EN adds skew_err_cnt_o, resync_cnt_o
// (saturating pulse counters) and max_skew_o (largest skew seen at STREAM entry).
//
// state  | meaning
// IDLE   | waiting for the first lane valid of a packet
// FILL   | some lanes started; counting skew until every lane has been seen
// STREAM | every lane seen; pop all FIFOs together whenever none is empty
// RESYNC | one cycle: pulse sync_reset_o, flush FIFOs, then IDLE
module dphy_lane_deskew
  import dphy_pkg::*;
#(
  parameter int DATA_LANES = 2,
  parameter int MAX_SKEW   = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         enable_i,
  input  logic                         pkt_done_i,
  input  logic [DATA_LANES*BYTE_W-1:0] byte_i,
  input  logic [DATA_LANES-1:0]        byte_valid_i,
  output logic                         sync_reset_o,
  output logic [DATA_LANES*BYTE_W-1:0] word_o,
  output logic                         valid_o,
  output logic                         skew_err_o
`ifdef DPHY_DESKEW_STATS_EN
  ,
  output logic [15:0]                  skew_err_cnt_o,
  output logic [15:0]                  resync_cnt_o,
  output logic [3:0]                   max_skew_o
`endif
);

  localparam int FIFO_DEPTH = MAX_SKEW + 1;

  deskew_state_t                state_q, state_d;
  logic [DATA_LANES-1:0]        seen_q, seen_d, seen_now;
  logic [3:0]                   skew_cnt_q, skew_cnt_d;
  logic                         skew_err_q, skew_err_d;
  logic                         valid_q, valid_d;
  logic [DATA_LANES*BYTE_W-1:0] word_q, word_d, rd_word;
  logic [DATA_LANES-1:0]        wr_en, empty, ovf;
  // Overflow already folds in the full condition, so full is not used here.
  logic [DATA_LANES-1:0]        full_unused;
  logic                         rd_en, flush, going_resync, active, any_ovf;

  for (genvar i = 0; i < DATA_LANES; i++) begin : g_lane
    dphy_deskew_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .wr_en_i    (wr_en[i]),
      .wr_data_i  (byte_i[i*BYTE_W +: BYTE_W]),
      .rd_en_i    (rd_en),
      .flush_i    (flush),
      .rd_data_o  (rd_word[i*BYTE_W +: BYTE_W]),
      .empty_o    (empty[i]),
      .full_o     (full_unused[i]),
      .overflow_o (ovf[i])
    );
  end

  // Datapath control derived from the current state.
  always_comb begin
    active   = enable_i && (state_q != RESYNC);
    wr_en    = active ? byte_valid_i : '0;
    // Pop is allowed in FILL too so a zero-skew packet sees 1-clk latency.
    rd_en    = enable_i && ((state_q == FILL) || (state_q == STREAM)) && !(|empty);
    any_ovf  = ((state_q == FILL) || (state_q == STREAM)) && (|ovf);
    seen_now = seen_q | byte_valid_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      seen_q     <= '0;
      skew_cnt_q <= '0;
      skew_err_q <= 1'b0;
      valid_q    <= 1'b0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      seen_q     <= seen_d;
      skew_cnt_q <= skew_cnt_d;
      skew_err_q <= skew_err_d;
      valid_q    <= valid_d;
      word_q     <= word_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seen_d     = seen_q;
    skew_cnt_d = skew_cnt_q;
    skew_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i && (|byte_valid_i)) begin
          state_d    = FILL;
          seen_d     = byte_valid_i;
          skew_cnt_d = '0;
        end
      end
      FILL: begin
        skew_cnt_d = skew_cnt_q + 4'd1;
        seen_d     = seen_now;
        // pkt_done/disable outrank errors, so a coincident overflow raises no skew_err.
        if (!enable_i || pkt_done_i) begin
          state_d = RESYNC;
        end else if (any_ovf) begin
          state_d    = RESYNC;
          skew_err_d = 1'b1;
        end else if (&seen_now) begin
          state_d = STREAM;
        end else if (skew_cnt_d == 4'(MAX_SKEW)) begin
          state_d    = RESYNC;
          skew_err_d = 1'b1;
        end
      end
      STREAM: begin
        if (!enable_i || pkt_done_i) begin
          state_d = RESYNC;
        end else if (any_ovf) begin
          state_d    = RESYNC;
          skew_err_d = 1'b1;
        end
      end
      RESYNC: begin
        state_d    = IDLE;
        seen_d     = '0;
        skew_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    going_resync = (state_d == RESYNC) && (state_q != RESYNC);
    // Flushing on the entry edge leaves the FIFOs empty during the RESYNC cycle.
    flush        = going_resync || (state_q == RESYNC) || !enable_i;
    valid_d      = rd_en && !going_resync;
    if (!enable_i)    word_d = '0;
    else if (valid_d) word_d = rd_word;
    else              word_d = word_q;
    sync_reset_o = (state_q == RESYNC);
    skew_err_o   = skew_err_q;
    valid_o      = valid_q;
    word_o       = word_q;
  end

`ifdef DPHY_DESKEW_STATS_EN
  logic [15:0] skew_err_cnt_q, resync_cnt_q;
  logic [3:0]  max_skew_q, fill_skew;

  // If all lanes were already seen on FILL entry the packet had zero skew.
  always_comb fill_skew = (&seen_q) ? skew_cnt_q : skew_cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      skew_err_cnt_q <= '0;
      resync_cnt_q   <= '0;
      max_skew_q     <= '0;
    end else begin
      if (skew_err_q && (skew_err_cnt_q != 16'hFFFF)) skew_err_cnt_q <= skew_err_cnt_q + 16'd1;
      if ((state_q == RESYNC) && (resync_cnt_q != 16'hFFFF)) resync_cnt_q <= resync_cnt_q + 16'd1;
      if ((state_q == FILL) && (state_d == STREAM) && (fill_skew > max_skew_q)) max_skew_q <= fill_skew;
    end
  end

  always_comb begin
    skew_err_cnt_o = skew_err_cnt_q;
    resync_cnt_o   = resync_cnt_q;
    max_skew_o     = max_skew_q;
  end
`endif

endmodule

// File: tb/tb_dphy_lane_deskew.sv
module tb_dphy_lane_deskew;

  localparam int LANES = 4;

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic               enable_i;
  logic               pkt_done_i;
  logic [LANES*8-1:0] byte_i;
  logic [LANES-1:0]   byte_valid_i;
  logic               sync_reset_o;
  logic [LANES*8-1:0] word_o;
  logic               valid_o;
  logic               skew_err_o;
`ifdef DPHY_DESKEW_STATS_EN
  logic [15:0]        skew_err_cnt_o;
  logic [15:0]        resync_cnt_o;
  logic [3:0]         max_skew_o;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  dphy_lane_deskew #(.DATA_LANES(LANES), .MAX_SKEW(3)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .pkt_done_i   (pkt_done_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .sync_reset_o (sync_reset_o),
    .word_o       (word_o),
    .valid_o      (valid_o),
    .skew_err_o   (skew_err_o)
`ifdef DPHY_DESKEW_STATS_EN
    ,
    .skew_err_cnt_o (skew_err_cnt_o),
    .resync_cnt_o   (resync_cnt_o),
    .max_skew_o     (max_skew_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every valid_o output word is popped and compared.
  always @(negedge clk_i) begin
    if (rst_n_i === 1'b1 && valid_o === 1'b1) begin
      if (exp_q.size() == 0) check_eq("unexpected_word", 32'(valid_o), 32'd0);
      else                   check_eq("word", word_o, exp_q.pop_front());
    end
  end

  function automatic logic [31:0] wrd(input int j);
    return {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] b);
    byte_valid_i = v;
    byte_i       = b;
  endtask

  task automatic end_pkt(input string tag);
    pkt_done_i = 1'b1;
    cyc();
    pkt_done_i = 1'b0;
    check_eq({tag, "_sync"}, 32'(sync_reset_o), 32'd1);
    check_eq({tag, "_noerr"}, 32'(skew_err_o), 32'd0);
    check_eq({tag, "_novalid"}, 32'(valid_o), 32'd0);
    cyc();
    check_eq({tag, "_sync_end"}, 32'(sync_reset_o), 32'd0);
  endtask

  task automatic drain(input string tag);
    drive(4'h0, 32'h0);
    cyc();
    cyc();
    check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_pkt(input string tag, input int base, input int n);
    for (int j = 0; j < n; j++) begin
      drive(4'hF, wrd(base + j));
      exp_q.push_back(wrd(base + j));
      cyc();
      if (j == 0) check_eq({tag, "_lat0"}, 32'(valid_o), 32'd0);
      if (j == 1) check_eq({tag, "_lat1"}, 32'(valid_o), 32'd1);
    end
    drain(tag);
    end_pkt(tag);
  endtask

  // Lanes 1..3 keep writing while lane 0 stalls; optionally pkt_done on the overflow cycle.
  task automatic stall_test(input string tag, input bit coincide);
    for (int c = 0; c < 8; c++) begin
      drive((c < 3) ? 4'hF : 4'hE, wrd(16 + c));
      if (c < 3) exp_q.push_back(wrd(16 + c));
      pkt_done_i = coincide && (c == 7);
      cyc();
      check_eq({tag, "_err"}, 32'(skew_err_o), 32'(!coincide && c == 7));
      check_eq({tag, "_sync"}, 32'(sync_reset_o), 32'(c == 7));
      if (c == 7) check_eq({tag, "_novalid"}, 32'(valid_o), 32'd0);
    end
    pkt_done_i = 1'b0;
    drive(4'h0, 32'h0);
    cyc();
    check_eq({tag, "_sync_end"}, 32'(sync_reset_o), 32'd0);
    check_eq({tag, "_err_end"}, 32'(skew_err_o), 32'd0);
    check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wc;
    rst_n_i      = 1'b0;
    enable_i     = 1'b1;
    pkt_done_i   = 1'b0;
    byte_i       = '0;
    byte_valid_i = '0;
    #12;
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_word", word_o, 32'd0);
    check_eq("rst_sync", 32'(sync_reset_o), 32'd0);
    check_eq("rst_err", 32'(skew_err_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cyc();

    // Zero skew, 8 words.
    run_pkt("t1", 0, 8);

    // Lane 3 starts 3 clocks after lanes 0..2.
    for (int c = 0; c < 11; c++) begin
      wc = wrd(c);
      drive(((c < 8) ? 4'b0111 : 4'b0000) | ((c >= 3) ? 4'b1000 : 4'b0000),
            {8'(4*(c-3)+3), wc[23:0]});
      if (c >= 3) exp_q.push_back(wrd(c - 3));
      cyc();
      check_eq("t2_noerr", 32'(skew_err_o), 32'd0);
      if (c == 3) check_eq("t2_lat0", 32'(valid_o), 32'd0);
      if (c == 4) check_eq("t2_lat1", 32'(valid_o), 32'd1);
    end
    drain("t2");
    end_pkt("t2");

    // Lane 3 never valid: skew error after MAX_SKEW clocks of FILL.
    for (int c = 0; c < 4; c++) begin
      drive(4'b0111, wrd(c));
      cyc();
      check_eq("t3_err", 32'(skew_err_o), 32'(c == 3));
      check_eq("t3_sync", 32'(sync_reset_o), 32'(c == 3));
      check_eq("t3_novalid", 32'(valid_o), 32'd0);
    end
    drive(4'h0, 32'h0);
    cyc();
    check_eq("t3_err_end", 32'(skew_err_o), 32'd0);
    check_eq("t3_sync_end", 32'(sync_reset_o), 32'd0);

    // pkt_done in IDLE is ignored.
    pkt_done_i = 1'b1;
    cyc();
    pkt_done_i = 1'b0;
    check_eq("idle_pkt_done", 32'(sync_reset_o), 32'd0);

    stall_test("t4_ovf", 1'b0);
    stall_test("t5_pkt_ovf", 1'b1);
    // Any stale FIFO entry would corrupt these words.
    run_pkt("t5_clean", 32, 2);

`ifdef DPHY_DESKEW_STATS_EN
    check_eq("stat_err_cnt", 32'(skew_err_cnt_o), 32'd2);
    check_eq("stat_resync_cnt", 32'(resync_cnt_o), 32'd6);
    check_eq("stat_max_skew", 32'(max_skew_o), 32'd3);
`endif

    // Asynchronous reset in the middle of STREAM.
    for (int c = 0; c < 3; c++) begin
      drive(4'hF, wrd(40 + c));
      exp_q.push_back(wrd(40 + c));
      cyc();
    end
    check_eq("t6_streaming", 32'(valid_o), 32'd1);
    #1;
    rst_n_i = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(valid_o), 32'd0);
    check_eq("t6_rst_word", word_o, 32'd0);
    check_eq("t6_rst_sync", 32'(sync_reset_o), 32'd0);
    exp_q.delete();
    drive(4'h0, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cyc();
    check_eq("t6_post_sync", 32'(sync_reset_o), 32'd0);
`ifdef DPHY_DESKEW_STATS_EN
    check_eq("t6_err_cnt_clr", 32'(skew_err_cnt_o), 32'd0);
    check_eq("t6_resync_cnt_clr", 32'(resync_cnt_o), 32'd0);
    check_eq("t6_max_skew_clr", 32'(max_skew_o), 32'd0);
`endif
    run_pkt("t6_recover", 50, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
